uart_rx_frame: RTL and testbench

- Synthesizable, parametrised UART receiver for the CORDIC-UART datapath.
- Converts the serial rx line into parallel words with valid/ready handshake, parity and framing status, and overrun detection.
- Generalises the fixed 11-bit frame (start, 8 data, parity, stop) to configurable data width, parity mode, stop-bit count and bit period.
- Sits between the board rx pin and the command decoder feeding the CORDIC core.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx_frame.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int DEF_DATA_BITS   = 8;
    localparam int DEF_PARITY_MODE = 1;
    localparam int DEF_STOP_BITS   = 1;
    localparam int FRAME_BITS      = 1 + DEF_DATA_BITS + ((DEF_PARITY_MODE != 0) ? 1 : 0) + DEF_STOP_BITS;

    // Expected parity bit for a word; narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input parity_mode_e mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose: 2-flop synchroniser for the rx pin with falling-edge pulse.
// Latency: 2 cycles pin to rx_sync, fall pulse the cycle the synced value drops.
// Backpressure: none, free-running.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_sync,
    output logic rx_fall
);

    logic       rx_meta;
    logic       rx_prev;
    logic [2:0] fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            fill    <= 3'b000;
        end else begin
            rx_meta <= rx_async;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            fill    <= {fill[1:0], 1'b1};
        end
    end

    // Edges are ignored until the pipeline holds real pin samples, so a line
    // already low at reset release does not look like a start bit.
    assign rx_fall = fill[2] & rx_prev & ~rx_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// Purpose: UART receiver, configurable width/parity/stop bits; UART_RX_MAJORITY_EN selects 2-of-3 bit voting.
// Latency: o_valid rises 1 cycle after the stop-bit decision (decision lands 1 cycle after mid-bit).
// Backpressure: valid/ready; a frame completing while a word is held unaccepted is dropped with o_overrun.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int                CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]     FULL  = CW'(CLKS_PER_BIT - 1);
    localparam parity_mode_e      PMODE = parity_mode_e'(2'(PARITY_MODE));

    logic                 rx_s;
    logic                 rx_fall;
    logic                 bit_val;
    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;
    logic                 done;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_async (i_rx),
        .rx_sync  (rx_s),
        .rx_fall  (rx_fall)
    );

    // Decisions are taken one cycle after mid-bit in both builds: rx_s is the
    // +1 sample and the history holds the centre (and -1) samples.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rx_s};
    end
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    logic hist;
    always_ff @(posedge clk) begin
        if (rst) hist <= 1'b1;
        else     hist <= rx_s;
    end
    assign bit_val = hist;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            done         <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            done      <= 1'b0;
            o_overrun <= 1'b0;

            if (done) begin
                if (!o_valid || i_ready) begin
                    o_data       <= shreg;
                    o_parity_err <= par_err;
                    o_frame_err  <= frm_err;
                    o_valid      <= 1'b1;
                end else begin
                    o_overrun    <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid      <= 1'b0;
                o_parity_err <= 1'b0;
                o_frame_err  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state  <= START;
                        cnt    <= HALF;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (bit_val) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        state   <= DATA;
                        cnt     <= FULL;
                        bit_idx <= '0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        cnt   <= FULL;
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_err <= (bit_val != calc_parity(9'(shreg), PMODE));
                        cnt     <= FULL;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!bit_val) frm_err <= 1'b1;
                        if (bit_idx == 4'(STOP_BITS - 1)) begin
                            // Back to IDLE now so a start edge half a bit later is caught.
                            state   <= IDLE;
                            o_busy  <= 1'b0;
                            done    <= 1'b1;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            cnt     <= FULL;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame at CLKS_PER_BIT=32, 8 data bits, even parity, 1 stop bit.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int CPB  = 32;
    localparam int NCYC = FRAME_BITS * CPB;
    // Line mid-stop-bit, plus 2 sync flops, 1 vote cycle, 1 delivery cycle.
    localparam int LAT  = CPB / 2 + (FRAME_BITS - 1) * CPB + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int ovr_cyc = -1;
    int ovr_cnt = 0;
    int busy_cnt = 0;
    logic prev_valid = 1'b0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_MODE  (1),
        .STOP_BITS    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (o_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        prev_valid = o_valid;
        if (o_overrun === 1'b1) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (o_busy === 1'b1) busy_cnt++;
        if (o_valid === 1'b1 && i_ready === 1'b1) got_q.push_back({o_data, o_parity_err, o_frame_err});
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives up to ncyc cycles of an 8E1 frame; glitch inverts the line for one cycle.
    task automatic drive_frame(input logic [7:0] d, input logic p, input logic s,
                               input int glitch, input int ncyc);
        logic [FRAME_BITS-1:0] fb;
        fb = {s, p, d, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            i_rx = fb[c / CPB] ^ (c == glitch);
            @(posedge clk);
            #1;
        end
        i_rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_rx = 1'b0; i_ready = 1'b0;
        idle(3);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", o_valid); end
        total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", o_data); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
        total++; if (o_parity_err !== 1'b0 || o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
            bad++; $display("FAIL reset_flags got %b%b%b want 000", o_parity_err, o_frame_err, o_overrun);
        end
        rst = 1'b0;
        busy_cnt = 0;
        idle(3 * CPB);
        total++; if (busy_cnt !== 0) begin bad++; $display("FAIL low_at_release busy cycles got %0d want 0", busy_cnt); end
        i_rx = 1'b1;
        idle(10);
    endtask

    task automatic test_basic;
        int start;
        i_ready = 1'b0; rise_cyc = -1;
        start = cyc;
        drive_frame(8'hA5, 1'b0, 1'b1, -1, NCYC);
        idle(4);
        total++; if (rise_cyc !== start + LAT) begin bad++; $display("FAIL basic_latency got %0d want %0d", rise_cyc - start, LAT); end
        total++; if (o_valid !== 1'b1 || o_data !== 8'hA5) begin bad++; $display("FAIL basic_data got %b/%h want 1/a5", o_valid, o_data); end
        total++; if (o_parity_err !== 1'b0 || o_frame_err !== 1'b0) begin bad++; $display("FAIL basic_flags got %b%b want 00", o_parity_err, o_frame_err); end
        i_ready = 1'b1;
        idle(1);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_accept got %b want 0", o_valid); end
    endtask

    task automatic test_parity;
        i_ready = 1'b0;
        drive_frame(8'h3C, 1'b1, 1'b1, -1, NCYC);
        idle(4);
        total++; if (o_valid !== 1'b1 || o_data !== 8'h3C) begin bad++; $display("FAIL parity_data got %b/%h want 1/3c", o_valid, o_data); end
        total++; if (o_parity_err !== 1'b1 || o_frame_err !== 1'b0) begin bad++; $display("FAIL parity_flags got %b%b want 10", o_parity_err, o_frame_err); end
        i_ready = 1'b1;
        idle(1);
        total++; if (o_valid !== 1'b0 || o_parity_err !== 1'b0) begin bad++; $display("FAIL parity_clear got %b%b want 00", o_valid, o_parity_err); end
    endtask

    task automatic test_framing;
        i_ready = 1'b0;
        drive_frame(8'h81, 1'b0, 1'b0, -1, NCYC);
        idle(4);
        total++; if (o_data !== 8'h81 || o_frame_err !== 1'b1 || o_parity_err !== 1'b0) begin
            bad++; $display("FAIL frame_err got %h/%b%b want 81/01", o_data, o_parity_err, o_frame_err);
        end
        i_ready = 1'b1;
        idle(CPB);
        i_ready = 1'b0;
        drive_frame(8'h55, 1'b0, 1'b1, -1, NCYC);
        idle(4);
        total++; if (o_valid !== 1'b1 || o_data !== 8'h55 || o_frame_err !== 1'b0) begin
            bad++; $display("FAIL frame_recover got %b/%h/%b want 1/55/0", o_valid, o_data, o_frame_err);
        end
        i_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_back_to_back;
        int start2;
        i_ready = 1'b0; ovr_cnt = 0; ovr_cyc = -1;
        got_q.delete();
        drive_frame(8'h11, 1'b0, 1'b1, -1, NCYC);
        start2 = cyc;
        drive_frame(8'h22, 1'b0, 1'b1, -1, NCYC);
        idle(5);
        total++; if (o_valid !== 1'b1 || o_data !== 8'h11) begin bad++; $display("FAIL b2b_held got %b/%h want 1/11", o_valid, o_data); end
        total++; if (ovr_cnt !== 1) begin bad++; $display("FAIL b2b_overrun_cycles got %0d want 1", ovr_cnt); end
        total++; if (ovr_cyc !== start2 + LAT) begin bad++; $display("FAIL b2b_overrun_time got %0d want %0d", ovr_cyc - start2, LAT); end
        i_ready = 1'b1;
        idle(1);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL b2b_accept got %b want 0", o_valid); end
        idle(CPB);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL b2b_count got %0d want 1", got_q.size()); end
    endtask

    task automatic test_glitch;
        i_ready = 1'b1; busy_cnt = 0;
        got_q.delete();
        for (int c = 0; c < 10; c++) begin
            i_rx = 1'b0;
            idle(1);
        end
        i_rx = 1'b1;
        idle(2 * CPB);
        total++; if (busy_cnt < 16 || busy_cnt > 18) begin bad++; $display("FAIL glitch_busy got %0d want 16..18", busy_cnt); end
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL glitch_output got %0d words want 0", got_q.size()); end
`ifdef UART_RX_MAJORITY_EN
        // One-cycle dip on the centre sample of data bit 3 (frame bit 4).
        drive_frame(8'hFF, 1'b0, 1'b1, 4 * CPB + CPB / 2 - 1, NCYC);
        idle(10);
        total++; if (got_q.size() !== 1 || got_q[0] !== {8'hFF, 2'b00}) begin
            bad++; $display("FAIL majority_glitch got n=%0d %h want n=1 %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, {8'hFF, 2'b00});
        end
`endif
    endtask

    task automatic test_break;
        i_ready = 1'b1;
        got_q.delete();
        i_rx = 1'b0;
        idle((FRAME_BITS + 3) * CPB);
        total++; if (got_q.size() !== 1 || got_q[0] !== {8'h00, 1'b0, 1'b1}) begin
            bad++; $display("FAIL break_word got n=%0d %h want n=1 %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, {8'h00, 2'b01});
        end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL break_idle got busy %b want 0", o_busy); end
        i_rx = 1'b1;
        idle(CPB);
    endtask

    task automatic test_reset_mid;
        i_ready = 1'b1;
        got_q.delete();
        drive_frame(8'h5A, 1'b0, 1'b1, -1, 5 * CPB + 10);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2 * CPB);
        total++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_state got %b%b want 00", o_busy, o_valid); end
        drive_frame(8'h96, 1'b0, 1'b1, -1, NCYC);
        idle(10);
        total++; if (got_q.size() !== 1 || got_q[0] !== {8'h96, 2'b00}) begin
            bad++; $display("FAIL rstmid_word got n=%0d %h want n=1 %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, {8'h96, 2'b00});
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic p, s, wrong;
        i_ready = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom_range(0, 255));
            wrong = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) != 0);
            p = (^d) ^ wrong;
            // Even parity: error when data plus parity bit hold an odd number of ones.
            exp_q.push_back({d, wrong, ~s});
            drive_frame(d, p, s, -1, NCYC);
            idle($urandom_range(1, 40));
        end
        idle(CPB);
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_framing;
        test_back_to_back;
        test_glitch;
        test_break;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
